// File: rtl/instruction_fetch.sv
// Instruction fetch front end: PC register, imem req/ready fetch FSM, field decode, next-PC select.
// Optional branch delay slot behaviour is enabled by defining IFETCH_DELAY_SLOT_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        advance,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jal,
    input  logic        jr,
    input  logic [31:0] Da,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] PC,
    output logic [5:0]  opcode,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] target26,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        VALID
    } state_t;

    localparam logic [15:0] TMO = 16'(WAIT_TIMEOUT);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_nxt;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        err_q;

    logic [31:0] pc1;
    logic [31:0] br_pc;
    logic [31:0] jmp_pc;
    logic [31:0] jr_pc;
    logic [31:0] next_pc;
    logic [31:0] pc_load;

    always_comb begin
        pc1    = pc_q + 32'd1;
        br_pc  = pc1 + {{16{instr_q[15]}}, instr_q[15:0]};
        jmp_pc = {pc1[31:26], instr_q[25:0]};
        jr_pc  = {2'b00, Da[31:2]};
        if (jr)
            next_pc = jr_pc;
        else if (jump || jal)
            next_pc = jmp_pc;
        else if (branch && zero)
            next_pc = br_pc;
        else
            next_pc = pc1;
    end

`ifdef IFETCH_DELAY_SLOT_EN
    logic        pend_q;
    logic [31:0] pend_pc_q;
    logic        taken;

    assign taken = jr || jump || jal || (branch && zero);

    // A pending target always wins over the delay-slot instruction's own transfer
    always_comb begin
        pc_load = pc1;
        if (pend_q)
            pc_load = pend_pc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q    <= 1'b0;
            pend_pc_q <= 32'd0;
        end else if (state_q == VALID && advance) begin
            if (pend_q) begin
                pend_q <= 1'b0;
            end else if (taken) begin
                pend_q    <= 1'b1;
                pend_pc_q <= next_pc;
            end
        end
    end
`else
    assign pc_load = next_pc;
`endif

    assign cnt_nxt = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (imem_ready) state_d = VALID;
            VALID:   if (advance) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == REQ) begin
                if (imem_ready) begin
                    instr_q <= imem_rdata;
                    cnt_q   <= 16'd0;
                end else begin
                    cnt_q <= cnt_nxt;
                    if (cnt_nxt >= TMO)
                        err_q <= 1'b1;
                end
            end
            if (state_q == VALID && advance)
                pc_q <= pc_load;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == VALID);
    assign instruction = instr_q;
    assign PC          = pc_q;
    assign fetch_err   = err_q;
    assign opcode      = instr_q[31:26];
    assign Rs          = instr_q[25:21];
    assign Rt          = instr_q[20:16];
    assign Rd          = instr_q[15:11];
    assign funct       = instr_q[5:0];
    assign imm16       = instr_q[15:0];
    assign target26    = instr_q[25:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed next-PC vectors, stalls, timeout, reset.
// Define IFETCH_DELAY_SLOT_EN to run the delay-slot sequence instead of the immediate-transfer one.
module tb_instruction_fetch;

    localparam logic [31:0] RPC = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata = 32'd0;
    logic        advance, branch, zero, jump, jal, jr;
    logic [31:0] Da;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] PC;
    logic [5:0]  opcode;
    logic [4:0]  Rs, Rt, Rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic        fetch_err;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC(RPC),
        .WAIT_TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .advance(advance), .branch(branch), .zero(zero),
        .jump(jump), .jal(jal), .jr(jr), .Da(Da),
        .instr_valid(instr_valid), .instruction(instruction), .PC(PC),
        .opcode(opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .funct(funct),
        .imm16(imm16), .target26(target26), .fetch_err(fetch_err)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [logic [31:0]];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a))
            return mem[a];
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) imem_rdata = rd_word(imem_addr);

    logic prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (instr_valid && !prev_v) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty: fetch at PC %0h with no expectation", PC);
            end else begin
                e = sb.pop_front();
                chk("pc", 64'(PC), 64'(e.pc));
                chk("instr", 64'(instruction), 64'(e.ins));
                chk("regs", 64'({opcode, Rs, Rt, Rd, funct}),
                    64'({e.ins[31:26], e.ins[25:21], e.ins[20:16], e.ins[15:11], e.ins[5:0]}));
                chk("imm", 64'({imm16, target26}), 64'({e.ins[15:0], e.ins[25:0]}));
            end
        end
        prev_v = instr_valid;
    end

    task automatic wait_valid();
        for (int k = 0; k < 50 && !instr_valid; k++)
            @(negedge clk);
        if (!instr_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_valid: instr_valid=0 required 1 after 50 cycles");
        end
    endtask

    task automatic adv(input logic j_r, input logic jmp, input logic jl,
                       input logic br, input logic z, input logic [31:0] da,
                       input logic [31:0] exp_pc, input bit push);
        wait_valid();
        jr = j_r; jump = jmp; jal = jl; branch = br; zero = z; Da = da;
        advance = 1'b1;
        if (push)
            sb.push_back('{pc: exp_pc, ins: rd_word(exp_pc)});
        @(posedge clk);
        #1;
        advance = 1'b0; jr = 1'b0; jump = 1'b0; jal = 1'b0;
        branch = 1'b0; zero = 1'b0; Da = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[32'h10]         = 32'h012A_4020;
        mem[32'h0]          = 32'h1000_FFFE;
        mem[32'h0400_0005]  = 32'h0C00_0100;
`ifdef IFETCH_DELAY_SLOT_EN
        mem[32'h20]         = 32'h1000_0004;
`else
        mem[32'h20]         = 32'h1000_FFFE;
`endif
        reset = 1'b1; imem_ready = 1'b1;
        advance = 1'b0; branch = 1'b0; zero = 1'b0;
        jump = 1'b0; jal = 1'b0; jr = 1'b0; Da = 32'd0;
        repeat (2) @(negedge clk);

        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_valid", 64'(instr_valid), 64'(0));
        chk("rst_pc", 64'(PC), 64'(RPC));
        chk("rst_instr", 64'(instruction), 64'(0));
        chk("rst_err", 64'(fetch_err), 64'(0));
        chk("rst_fields", 64'({Rs, Rt, Rd, funct}), 64'(0));

        sb.push_back('{pc: RPC, ins: rd_word(RPC)});
        reset = 1'b0;
        @(negedge clk);
        chk("first_req", 64'(imem_req), 64'(1));
        chk("first_addr", 64'(imem_addr), 64'(RPC));
        wait_valid();
        chk("dec_rs", 64'(Rs), 64'(9));
        chk("dec_rt", 64'(Rt), 64'(10));
        chk("dec_rd", 64'(Rd), 64'(8));
        chk("dec_funct", 64'(funct), 64'(32'h20));

`ifdef IFETCH_DELAY_SLOT_EN
        adv(1, 0, 0, 0, 0, 32'h80, 32'h11, 1);
        adv(0, 0, 0, 0, 0, 32'h0, 32'h20, 1);
        adv(0, 0, 0, 1, 1, 32'h0, 32'h21, 1);
        adv(0, 0, 0, 0, 0, 32'h0, 32'h25, 1);
`else
        adv(0, 0, 0, 0, 0, 32'h0, 32'h11, 1);
        adv(0, 0, 0, 0, 0, 32'h0, 32'h12, 1);
        imem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 64'(instr_valid), 64'(0));
            chk("stall_pc", 64'(PC), 64'(32'h12));
        end
        chk("stall_err", 64'(fetch_err), 64'(0));
        imem_ready = 1'b1;

        adv(1, 0, 0, 0, 0, 32'h80, 32'h20, 1);
        adv(0, 0, 0, 1, 1, 32'h0, 32'h1F, 1);
        adv(1, 0, 0, 0, 0, 32'h80, 32'h20, 1);
        adv(0, 0, 0, 1, 0, 32'h0, 32'h21, 1);
        adv(1, 0, 0, 0, 0, 32'h1000_0014, 32'h0400_0005, 1);
        adv(0, 0, 1, 0, 0, 32'h0, 32'h0400_0100, 1);
        adv(1, 0, 0, 0, 0, 32'h40, 32'h10, 1);
        adv(1, 1, 0, 0, 0, 32'hC0, 32'h30, 1);
        adv(0, 1, 0, 0, 0, 32'h0, 32'h03CF_0030, 1);
        adv(1, 0, 0, 0, 0, 32'h0, 32'h0, 1);
        adv(0, 0, 0, 1, 1, 32'h0, 32'hFFFF_FFFF, 1);
        adv(0, 0, 0, 0, 0, 32'h0, 32'h0, 1);

        adv(0, 0, 0, 0, 0, 32'h0, 32'h1, 1);
        imem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_before", 64'(fetch_err), 64'(0));
        @(posedge clk);
        #1;
        chk("tmo_set", 64'(fetch_err), 64'(1));
        imem_ready = 1'b1;
        wait_valid();
        chk("tmo_sticky", 64'(fetch_err), 64'(1));

        adv(0, 0, 0, 0, 0, 32'h0, 32'h2, 0);
        imem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_req", 64'(imem_req), 64'(0));
        chk("midrst_pc", 64'(PC), 64'(RPC));
        chk("midrst_err", 64'(fetch_err), 64'(0));
        chk("midrst_valid", 64'(instr_valid), 64'(0));
        @(negedge clk);
        imem_ready = 1'b1;
        sb.push_back('{pc: RPC, ins: rd_word(RPC)});
        reset = 1'b0;
        wait_valid();
`endif

        for (int k = 0; k < 50 && sb.size() != 0; k++)
            @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
